// File: rtl/i2c_slave_regs_if.sv
// I2C pad lines and register-port signals of the I2C slave register bridge.
// The slave modport is the bridge itself; master is the pad/register-file side.
interface i2c_slave_regs_if #(
  parameter int AW = 4
);
  logic          scl_in;
  logic          sda_in;
  logic          sda_oe;
  logic [AW-1:0] reg_addr;
  logic          reg_wr;
  logic [7:0]    reg_wdata;
  logic          reg_rd;
  logic [7:0]    reg_rdata;
  logic          busy;
  logic          nack_evt;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, reg_addr, reg_wr, reg_wdata, reg_rd, busy, nack_evt
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, reg_addr, reg_wr, reg_wdata, reg_rd, busy, nack_evt
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C slave bridging an external master to a NUM_REGS x 8-bit register port.
// 7-bit addressing, pointer byte, auto-increment with wrap, repeated START,
// STOP anywhere. SCL/SDA are oversampled on clk; nothing runs on SCL.
// FILT_LEN must be >= 2 and HOLD_CLKS >= 2: read data is latched two clks
// after the SCL fall and must be in the shift register before it is driven.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         NUM_REGS   = 16,
  parameter int         FILT_LEN   = 3,
  parameter int         HOLD_CLKS  = 4
) (
  input logic               clk,
  input logic               rst_n,
  i2c_slave_regs_if.slave   bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int HW = $clog2(HOLD_CLKS + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // line index 1 = SCL, 0 = SDA
  logic [1:0]               pin;
  logic [1:0]               sync1, sync2, filt, filt_q;
  logic [1:0][FILT_LEN-1:0] hist;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic          ack_on;
  logic          rw;
  logic [HW-1:0] hold_cnt;
  logic          sda_oe_q, reg_wr_q, reg_rd_q, busy_q, nack_q;
  logic [7:0]    wdata_q;

  logic          scl, sda, scl_q, sda_q;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    byte_in;
  logic [AW-1:0] ptr_inc;
  logic          drv;

  assign pin = {bus.scl_in, bus.sda_in};

  // 2-FF synchronizer then a stable filter: output only follows once the
  // last FILT_LEN synchronized samples all agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      hist   <= '1;
      filt   <= '1;
      filt_q <= '1;
    end else begin
      sync1  <= pin;
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        hist[i] <= {hist[i][FILT_LEN-2:0], sync2[i]};
        if (&hist[i])       filt[i] <= 1'b1;
        else if (~|hist[i]) filt[i] <= 1'b0;
      end
    end
  end

  assign scl       = filt[1];
  assign sda       = filt[0];
  assign scl_q     = filt_q[1];
  assign sda_q     = filt_q[0];
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;
  assign byte_in   = {shreg[6:0], sda};
  assign ptr_inc   = (ptr == AW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;

  // SDA level to present once the hold time after an SCL fall has elapsed
  always_comb begin
    drv = 1'b0;
    case (state)
      ADDR_ACK, PTR_ACK, WDATA_ACK: drv = ack_on;
      RDATA:                        drv = ~shreg[7];
      default:                      drv = 1'b0;
    endcase
  end

  // Protocol FSM: START/STOP override everything, bits are sampled on SCL
  // rise, phase changes happen on SCL fall, SDA moves HOLD_CLKS later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      hold_cnt <= '0;
      sda_oe_q <= 1'b0;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      nack_q   <= 1'b0;
      // register file answers in the clk the read strobe is high
      if (reg_rd_q) shreg <= bus.reg_rdata;
      if (hold_cnt != '0) begin
        hold_cnt <= HW'(hold_cnt - 1'b1);
        if (hold_cnt == HW'(1)) sda_oe_q <= drv;
      end

      if (start_det) begin
        state    <= ADDR;
        busy_q   <= 1'b1;
        bit_cnt  <= '0;
        ack_on   <= 1'b0;
        sda_oe_q <= 1'b0;
        hold_cnt <= '0;
      end else if (stop_det) begin
        state    <= IDLE;
        busy_q   <= 1'b0;
        bit_cnt  <= '0;
        ack_on   <= 1'b0;
        sda_oe_q <= 1'b0;
        hold_cnt <= '0;
      end else if (scl_rise) begin
        case (state)
          ADDR, PTR, WDATA: begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              case (state)
                ADDR: begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    rw    <= byte_in[0];
                    state <= ADDR_ACK;
                  end else begin
                    state <= WAIT_STOP;
                  end
                end
                PTR: begin
                  if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                    ptr   <= AW'(byte_in);
                    state <= PTR_ACK;
                  end else begin
                    nack_q <= 1'b1;
                    state  <= WAIT_STOP;
                  end
                end
                default: begin
                  wdata_q  <= byte_in;
                  reg_wr_q <= 1'b1;
                  state    <= WDATA_ACK;
                end
              endcase
            end
          end
          RDATA: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RDATA_ACK;
          end
          // 9th clock of a read byte: master's ACK/NACK
          RDATA_ACK: begin
            if (!sda) begin
              ptr    <= ptr_inc;
              ack_on <= 1'b1;
            end else begin
              state <= WAIT_STOP;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        hold_cnt <= HW'(HOLD_CLKS);
        case (state)
          // first fall starts the ACK slot, second fall ends it
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (!ack_on) begin
              ack_on <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= '0;
              case (state)
                ADDR_ACK: begin
                  if (rw) begin
                    reg_rd_q <= 1'b1;
                    state    <= RDATA;
                  end else begin
                    state <= PTR;
                  end
                end
                PTR_ACK: state <= WDATA;
                default: begin
                  ptr   <= ptr_inc;
                  state <= WDATA;
                end
              endcase
            end
          end
          RDATA: shreg <= {shreg[6:0], 1'b0};
          RDATA_ACK: begin
            if (ack_on) begin
              ack_on   <= 1'b0;
              bit_cnt  <= '0;
              reg_rd_q <= 1'b1;
              state    <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_addr  = ptr;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.busy      = busy_q;
  assign bus.nack_evt  = nack_q;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged I2C master drives the bus,
// expected register strobes go into queues, a monitor pops and compares them.
module tb_i2c_slave_regs;
  localparam int Q = 16; // clks per quarter SCL period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  always #5 clk = ~clk;

  i2c_slave_regs_if #(.AW(4)) bus();

  assign bus.scl_in    = scl_m;
  assign bus.sda_in    = sda_m & ~bus.sda_oe;
  assign bus.reg_rdata = 8'h10 + {4'h0, bus.reg_addr};

  i2c_slave_regs #(
    .SLAVE_ADDR(7'h55), .NUM_REGS(16), .FILT_LEN(3), .HOLD_CLKS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [11:0] exp_wr[$];   // {addr, data}
  logic [3:0]  exp_rd[$];   // addr
  logic [3:0]  exp_nack[$]; // pointer at NACK (unchanged)
  int busy_cnt = 0;
  int oe_cnt = 0;
  logic nack_d = 1'b0;
  logic [11:0] m_wr;
  logic [3:0]  m_rd, m_nk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // monitor: compares every strobe the DUT presents against the queues
  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.sda_oe) oe_cnt++;
    if (rst_n) begin
      if (bus.reg_wr && bus.reg_rd) begin
        n_chk++; n_err++;
        $display("FAIL wr_rd_overlap: got both strobes, expected at most one");
      end
      if (bus.reg_wr) begin
        if (exp_wr.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL reg_wr: got addr=%0h data=%0h, expected no write", bus.reg_addr, bus.reg_wdata);
        end else begin
          m_wr = exp_wr.pop_front();
          chk("reg_wr addr/data", {bus.reg_addr, bus.reg_wdata}, m_wr);
        end
      end
      if (bus.reg_rd) begin
        if (exp_rd.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL reg_rd: got addr=%0h, expected no read", bus.reg_addr);
        end else begin
          m_rd = exp_rd.pop_front();
          chk("reg_rd addr", bus.reg_addr, m_rd);
        end
      end
      if (bus.nack_evt) begin
        if (nack_d) begin
          n_chk++; n_err++;
          $display("FAIL nack_evt width: got >1 clk, expected 1 clk");
        end else if (exp_nack.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL nack_evt: got pulse, expected none");
        end else begin
          m_nk = exp_nack.pop_front();
          chk("nack_evt ptr", bus.reg_addr, m_nk);
        end
      end
    end
    nack_d = bus.nack_evt;
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wclk(Q);
    scl_m = 1'b1; wclk(2 * Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  // bit with a 1-clk opposite-level SDA pulse in the middle of SCL high
  task automatic write_bit_glitch(input logic b);
    sda_m = b;    wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = ~b;   wclk(1);
    sda_m = b;    wclk(Q - 1);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    b = bus.sda_in; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~mack);
  endtask

  task automatic drain(input string nm);
    chk(nm, exp_wr.size() + exp_rd.size() + exp_nack.size(), 0);
    exp_wr.delete(); exp_rd.delete(); exp_nack.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack;
    logic [7:0] d;
    int bc, oc;

    // reset state
    rst_n = 1'b0; wclk(5);
    chk("reset sda_oe", bus.sda_oe, 0);
    rst_n = 1'b1; wclk(10);
    chk("reset busy", bus.busy, 0);
    chk("reset reg_addr", bus.reg_addr, 0);
    chk("reset strobes", {bus.reg_wr, bus.reg_rd, bus.nack_evt, bus.reg_wdata}, 0);

    // write ptr 3, two data bytes
    i2c_start();
    write_byte(8'hAA, ack); chk("t1 addr ack", ack, 1);
    write_byte(8'h03, ack); chk("t1 ptr ack", ack, 1);
    exp_wr.push_back({4'h3, 8'h5A});
    write_byte(8'h5A, ack); chk("t1 d0 ack", ack, 1);
    exp_wr.push_back({4'h4, 8'hC3});
    write_byte(8'hC3, ack); chk("t1 d1 ack", ack, 1);
    chk("t1 busy mid", bus.busy, 1);
    i2c_stop(); wclk(10);
    chk("t1 busy after stop", bus.busy, 0);
    chk("t1 ptr", bus.reg_addr, 5);
    drain("t1 queues empty");

    // combined ptr write / repeated-START read of 3 bytes
    i2c_start();
    write_byte(8'hAA, ack); chk("t2 addr ack", ack, 1);
    write_byte(8'h02, ack); chk("t2 ptr ack", ack, 1);
    i2c_start();
    exp_rd.push_back(4'h2);
    write_byte(8'hAB, ack); chk("t2 raddr ack", ack, 1);
    exp_rd.push_back(4'h3);
    read_byte(1'b1, d); chk("t2 rd0", d, 8'h12);
    exp_rd.push_back(4'h4);
    read_byte(1'b1, d); chk("t2 rd1", d, 8'h13);
    read_byte(1'b0, d); chk("t2 rd2", d, 8'h14);
    i2c_stop(); wclk(10);
    chk("t2 ptr", bus.reg_addr, 4);
    chk("t2 busy", bus.busy, 0);
    drain("t2 queues empty");

    // pointer wrap on write
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h0F, ack); chk("t3 ptr ack", ack, 1);
    exp_wr.push_back({4'hF, 8'h11});
    write_byte(8'h11, ack);
    exp_wr.push_back({4'h0, 8'h22});
    write_byte(8'h22, ack); chk("t3 d1 ack", ack, 1);
    i2c_stop(); wclk(10);
    chk("t3 ptr", bus.reg_addr, 1);
    drain("t3 queues empty");

    // wrong device address: slave stays off the bus until STOP
    oc = oe_cnt;
    i2c_start();
    write_byte(8'hA8, ack); chk("t4 addr nack", ack, 0);
    write_byte(8'h00, ack);
    write_byte(8'hFF, ack);
    chk("t4 busy before stop", bus.busy, 1);
    chk("t4 sda_oe never", oe_cnt - oc, 0);
    i2c_stop(); wclk(10);
    chk("t4 busy after stop", bus.busy, 0);
    drain("t4 queues empty");

    // out-of-range pointer
    i2c_start();
    write_byte(8'hAA, ack);
    exp_nack.push_back(4'h1);
    write_byte(8'h20, ack); chk("t5 ptr nack", ack, 0);
    write_byte(8'h77, ack); chk("t5 data nack", ack, 0);
    i2c_stop(); wclk(10);
    chk("t5 ptr kept", bus.reg_addr, 1);
    drain("t5 queues empty");

    // glitch while idle: no START/STOP
    bc = busy_cnt;
    sda_m = 1'b0; wclk(1);
    sda_m = 1'b1; wclk(20);
    chk("t6 idle glitch busy", busy_cnt - bc, 0);

    // glitch inside a data bit: byte still lands
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h05, ack);
    exp_wr.push_back({4'h5, 8'h3C});
    write_bit_glitch(1'b0);
    for (int i = 6; i >= 0; i--) write_bit(1'(8'h3C >> i));
    read_bit(ack); chk("t6 glitch byte ack", ack, 0);
    i2c_stop(); wclk(10);
    drain("t6 glitch queues empty");

    // STOP after 4 data bits: no write, back to idle
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h06, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop(); wclk(10);
    chk("t6 short stop busy", bus.busy, 0);
    chk("t6 short stop ptr", bus.reg_addr, 6);
    drain("t6 short queues empty");

    // reset in the middle of an ACK
    i2c_start();
    write_byte(8'hAA, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h07 >> i));
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    chk("t7 ack driven", bus.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("t7 async release", bus.sda_oe, 0);
    wclk(5);
    rst_n = 1'b1; wclk(20);
    chk("t7 busy after reset", bus.busy, 0);
    chk("t7 ptr after reset", bus.reg_addr, 0);
    i2c_start();
    write_byte(8'hAA, ack); chk("t7 restart ack", ack, 1);
    i2c_stop(); wclk(10);
    chk("t7 busy end", bus.busy, 0);
    drain("t7 queues empty");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
